// File: rtl/fp_axil_pkg.sv
// Shared types and field positions for the FrontPanel-driven AXI4-Lite master.
// Covers FSM states, status/ctrl/trigger bit positions and AXI response codes.
package fp_axil_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WRESP,
    S_READ,
    S_RDATA
  } state_e;

  localparam int ST_BUSY    = 0;
  localparam int ST_RESP_LO = 1;
  localparam int ST_RESP_HI = 2;
  localparam int ST_TIMEOUT = 3;
  localparam int ST_OVERRUN = 4;
  localparam int ST_CNT_LO  = 16;
  localparam int ST_CNT_HI  = 31;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CTRL_WRITE    = 0;
  localparam int CTRL_WSTRB_LO = 4;
  localparam int CTRL_WSTRB_HI = 7;

  localparam int TRIG_START = 0;
  localparam int TRIG_DONE  = 0;
  localparam int TRIG_ERR   = 1;

endpackage

// File: rtl/fp_axil_timeout.sv
// Per-transaction watchdog: 16-bit counter cleared on start, counting enabled cycles.
// expired_o flags the cycle whose closing edge brings the count up to LIMIT.
module fp_axil_timeout #(
  parameter int LIMIT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        cnt_q <= '0;
    else if (clear_i) cnt_q <= '0;
    else if (en_i)    cnt_q <= cnt_q + 16'd1;
  end

  assign expired_o = en_i && (cnt_q == 16'(LIMIT - 1));

endmodule

// File: rtl/fp_axil_master.sv
// Single-beat AXI4-Lite master driven by FrontPanel wire-ins/trigger-ins.
// Reports read data, response, timeout/overrun and a completion count on wire-outs.
module fp_axil_master
  import fp_axil_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        sync_clk,
  input  logic        peripheral_reset,
  input  logic [31:0] wi01_ep_dataout_addr,
  input  logic [31:0] wi02_ep_dataout_wdata,
  input  logic [31:0] wi03_ep_dataout_ctrl,
  input  logic [31:0] ti40_ep_trigger,
  output logic [31:0] to60_ep_trigger,
  output logic [31:0] wo20_ep_datain_rdata,
  output logic [31:0] wo21_ep_datain_status,
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  state_e      state_q;
  logic [29:0] addr_q;
  logic [31:0] wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic        aw_done_q, w_done_q;
  logic [1:0]  resp_q;
  logic        timeout_q, overrun_q, done_q, err_q;
  logic [15:0] count_q;

  logic busy, start, start_ok, expired;
  logic aw_done_d, w_done_d, ar_hs, b_hs, r_hs;

  assign busy     = (state_q != S_IDLE);
  assign start    = ti40_ep_trigger[TRIG_START];
  assign start_ok = start && !busy;

  assign aw_done_d = aw_done_q || (awvalid_q && m_axi_awready);
  assign w_done_d  = w_done_q  || (wvalid_q  && m_axi_wready);
  assign ar_hs     = arvalid_q && m_axi_arready;
  assign b_hs      = bready_q  && m_axi_bvalid;
  assign r_hs      = rready_q  && m_axi_rvalid;

  fp_axil_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk_i     (sync_clk),
    .rst_i     (peripheral_reset),
    .clear_i   (start_ok),
    .en_i      (busy),
    .expired_o (expired)
  );

  always_ff @(posedge sync_clk or posedge peripheral_reset) begin
    if (peripheral_reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      count_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (start && busy) overrun_q <= 1'b1;
      case (state_q)
        S_IDLE: if (start) begin
          addr_q    <= wi01_ep_dataout_addr[31:2];
          wdata_q   <= wi02_ep_dataout_wdata;
          wstrb_q   <= wi03_ep_dataout_ctrl[CTRL_WSTRB_HI:CTRL_WSTRB_LO];
          timeout_q <= 1'b0;
          overrun_q <= 1'b0;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          state_q   <= wi03_ep_dataout_ctrl[CTRL_WRITE] ? S_WRITE : S_READ;
        end
        // Valids rise on the first WRITE cycle and each falls on its own handshake.
        S_WRITE: begin
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          awvalid_q <= !aw_done_d;
          wvalid_q  <= !w_done_d;
          if (aw_done_d && w_done_d) begin
            bready_q <= 1'b1;
            state_q  <= S_WRESP;
          end
        end
        S_WRESP: if (b_hs) begin
          bready_q <= 1'b0;
          resp_q   <= m_axi_bresp;
          done_q   <= 1'b1;
          err_q    <= (m_axi_bresp != RESP_OKAY);
          count_q  <= count_q + 16'd1;
          state_q  <= S_IDLE;
        end
        S_READ: begin
          arvalid_q <= !ar_hs;
          if (ar_hs) begin
            rready_q <= 1'b1;
            state_q  <= S_RDATA;
          end
        end
        S_RDATA: if (r_hs) begin
          rready_q <= 1'b0;
          rdata_q  <= m_axi_rdata;
          resp_q   <= m_axi_rresp;
          done_q   <= 1'b1;
          err_q    <= (m_axi_rresp != RESP_OKAY);
          count_q  <= count_q + 16'd1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      // A completing handshake on the expiry edge wins over the abort.
      if (expired && !(b_hs || r_hs)) begin
        awvalid_q <= 1'b0;
        wvalid_q  <= 1'b0;
        bready_q  <= 1'b0;
        arvalid_q <= 1'b0;
        rready_q  <= 1'b0;
        timeout_q <= 1'b1;
        done_q    <= 1'b0;
        err_q     <= 1'b1;
        state_q   <= S_IDLE;
      end
    end
  end

  always_comb begin
    wo21_ep_datain_status                       = '0;
    wo21_ep_datain_status[ST_BUSY]              = busy;
    wo21_ep_datain_status[ST_RESP_HI:ST_RESP_LO] = resp_q;
    wo21_ep_datain_status[ST_TIMEOUT]           = timeout_q;
    wo21_ep_datain_status[ST_OVERRUN]           = overrun_q;
    wo21_ep_datain_status[ST_CNT_HI:ST_CNT_LO]  = count_q;
    to60_ep_trigger                             = '0;
    to60_ep_trigger[TRIG_DONE]                  = done_q;
    to60_ep_trigger[TRIG_ERR]                   = err_q;
  end

  assign wo20_ep_datain_rdata = rdata_q;
  assign m_axi_awaddr  = {addr_q, 2'b00};
  assign m_axi_araddr  = {addr_q, 2'b00};
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

  logic unused_bits;
  assign unused_bits = ^{wi01_ep_dataout_addr[1:0],
                         wi03_ep_dataout_ctrl[31:CTRL_WSTRB_HI+1],
                         wi03_ep_dataout_ctrl[CTRL_WSTRB_LO-1:CTRL_WRITE+1],
                         ti40_ep_trigger[31:TRIG_START+1]};

endmodule

// File: tb/tb_fp_axil_master.sv
// Bench for fp_axil_master: scripted AXI-Lite slave, transaction-level model checked
// every cycle, plus directed latency/handshake expectations worked out by hand.
module tb_fp_axil_master;
  import fp_axil_pkg::*;

  localparam int TO = 16;

  logic        sync_clk, peripheral_reset;
  logic [31:0] wi01, wi02, wi03, ti40, to60, wo20, wo21;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
  logic m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;

  fp_axil_master #(.TIMEOUT_CYCLES(TO)) dut (
    .sync_clk(sync_clk), .peripheral_reset(peripheral_reset),
    .wi01_ep_dataout_addr(wi01), .wi02_ep_dataout_wdata(wi02), .wi03_ep_dataout_ctrl(wi03),
    .ti40_ep_trigger(ti40), .to60_ep_trigger(to60),
    .wo20_ep_datain_rdata(wo20), .wo21_ep_datain_status(wo21),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  initial begin
    sync_clk = 1'b0;
    forever #5 sync_clk = ~sync_clk;
  end

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // ---------------- scripted slave ----------------
  int          aw_dly, w_dly, ar_dly, r_dly, b_dly;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp, s_bresp;
  int          aw_c, w_c, ar_c, r_c, b_c;
  logic p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr;
  logic got_aw, got_w, r_pend;

  initial begin
    {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid} = '0;
    m_axi_bresp = '0; m_axi_rresp = '0; m_axi_rdata = '0;
    {aw_c, w_c, ar_c, r_c, b_c} = '0;
    {p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr} = '0;
    {got_aw, got_w, r_pend} = '0;
    forever begin
      @(posedge sync_clk); #1;
      if (peripheral_reset) begin
        {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid} = '0;
        {aw_c, w_c, ar_c, r_c, b_c} = '0;
        {got_aw, got_w, r_pend} = '0;
      end else begin
        if (p_awv && p_awr) got_aw = 1'b1;
        if (p_wv && p_wr)   got_w  = 1'b1;
        if (p_bv && p_br) begin
          m_axi_bvalid = 1'b0; got_aw = 1'b0; got_w = 1'b0; b_c = 0;
        end else if (got_aw && got_w && !m_axi_bvalid) begin
          if (b_c >= b_dly) begin m_axi_bvalid = 1'b1; m_axi_bresp = s_bresp; end
          b_c++;
        end
        if (p_rv && p_rr) begin m_axi_rvalid = 1'b0; r_pend = 1'b0; end
        if (p_arv && p_arr) begin r_pend = 1'b1; r_c = 0; end
        if (r_pend && !m_axi_rvalid) begin
          if (r_c >= r_dly) begin
            m_axi_rvalid = 1'b1; m_axi_rdata = s_rdata; m_axi_rresp = s_rresp;
          end
          r_c++;
        end
        m_axi_awready = m_axi_awvalid && (aw_c >= aw_dly);
        aw_c = m_axi_awvalid ? aw_c + 1 : 0;
        m_axi_wready = m_axi_wvalid && (w_c >= w_dly);
        w_c = m_axi_wvalid ? w_c + 1 : 0;
        m_axi_arready = m_axi_arvalid && (ar_c >= ar_dly);
        ar_c = m_axi_arvalid ? ar_c + 1 : 0;
      end
      p_awv = m_axi_awvalid; p_awr = m_axi_awready;
      p_wv  = m_axi_wvalid;  p_wr  = m_axi_wready;
      p_bv  = m_axi_bvalid;  p_br  = m_axi_bready;
      p_arv = m_axi_arvalid; p_arr = m_axi_arready;
      p_rv  = m_axi_rvalid;  p_rr  = m_axi_rready;
    end
  end

  // ---------------- transaction-level model ----------------
  int          cyc, m_start;
  logic        m_busy, m_is_wr, m_done, m_err, m_timeout, m_overrun;
  logic [1:0]  m_resp;
  logic [31:0] m_rdata;
  logic [15:0] m_count;
  logic [31:0] m_status;
  logic        fin_hs;
  logic [1:0]  fin_resp;

  assign m_status = {m_count, 11'd0, m_overrun, m_timeout, m_resp, m_busy};
  assign fin_hs   = m_is_wr ? (m_axi_bvalid && m_axi_bready) : (m_axi_rvalid && m_axi_rready);
  assign fin_resp = m_is_wr ? m_axi_bresp : m_axi_rresp;

  always @(posedge sync_clk or posedge peripheral_reset) begin
    if (peripheral_reset) begin
      cyc <= 0; m_start <= 0;
      {m_busy, m_is_wr, m_done, m_err, m_timeout, m_overrun} <= '0;
      m_resp <= '0; m_rdata <= '0; m_count <= '0;
    end else begin
      cyc    <= cyc + 1;
      m_done <= 1'b0;
      m_err  <= 1'b0;
      if (!m_busy) begin
        if (ti40[0]) begin
          m_busy <= 1'b1; m_is_wr <= wi03[0]; m_start <= cyc;
          m_timeout <= 1'b0; m_overrun <= 1'b0;
        end
      end else begin
        if (ti40[0]) m_overrun <= 1'b1;
        if (fin_hs) begin
          m_busy <= 1'b0; m_done <= 1'b1; m_resp <= fin_resp;
          m_err <= (fin_resp != 2'b00);
          if (!m_is_wr) m_rdata <= m_axi_rdata;
          m_count <= m_count + 16'd1;
        end else if (cyc - m_start == TO) begin
          m_busy <= 1'b0; m_timeout <= 1'b1; m_err <= 1'b1;
        end
      end
    end
  end

  always @(negedge sync_clk) begin
    chk("to60", to60, {30'd0, m_err, m_done});
    chk("wo20", wo20, m_rdata);
    chk("wo21", wo21, m_status);
    if (!m_busy)
      chk("idle_bus", {20'd0, m_axi_awprot, m_axi_arprot, m_axi_awvalid, m_axi_wvalid,
                       m_axi_bready, m_axi_arvalid, m_axi_rready, 1'b0}, 32'd0);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge sync_clk);
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] d, input logic [31:0] c);
    tick();
    wi01 = a; wi02 = d; wi03 = c; ti40 = 32'd1;
    tick();
    ti40 = 32'd0;
  endtask

  task automatic wait_done(input int maxc, output int n);
    n = 0;
    while (to60 == 32'd0 && n < maxc) begin tick(); n++; end
    if (to60 == 32'd0) chk("done_wait", to60, 32'd1);
  endtask

  task automatic pulse_reset();
    tick(); #2;
    peripheral_reset = 1'b1;
    #1;
    chk("rst_now", {to60[1:0], wo20[0], wo21[4:0], m_axi_awvalid, m_axi_wvalid,
                    m_axi_bready, m_axi_arvalid, m_axi_rready}, 32'd0);
    chk("rst_status", wo21, 32'd0);
    tick();
    peripheral_reset = 1'b0;
  endtask

  int n;

  initial begin
    peripheral_reset = 1'b1;
    wi01 = '0; wi02 = '0; wi03 = '0; ti40 = '0;
    {aw_dly, w_dly, ar_dly, r_dly, b_dly} = '0;
    s_rdata = '0; s_rresp = RESP_OKAY; s_bresp = RESP_OKAY;
    tick(); tick();
    chk("reset_status", wo21, 32'd0);
    chk("reset_rdata", wo20, 32'd0);
    chk("reset_trig", to60, 32'd0);
    peripheral_reset = 1'b0;

    // 1: zero-wait write, AW and W in the same cycle, done 3 cycles after start
    start(32'h0000_1004, 32'hDEAD_BEEF, 32'h0000_00F1);
    chk("t1_n0_valids", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'd0);
    tick();
    chk("t1_n1_valids", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'd3);
    chk("t1_awaddr", m_axi_awaddr, 32'h0000_1004);
    chk("t1_wdata", m_axi_wdata, 32'hDEAD_BEEF);
    chk("t1_wstrb", {28'd0, m_axi_wstrb}, 32'hF);
    tick();
    chk("t1_n2_vvb", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'b001);
    tick();
    chk("t1_done", to60, 32'd1);
    chk("t1_status", wo21, 32'h0001_0000);

    // 2: read with arready 5 late and rvalid 2 more late
    ar_dly = 5; r_dly = 2; s_rdata = 32'h1234_5678;
    start(32'h0000_1004, 32'd0, 32'd0);
    tick();
    chk("t2_araddr", m_axi_araddr, 32'h0000_1004);
    wait_done(30, n);
    chk("t2_latency", n + 1, 32'd10);
    chk("t2_rdata", wo20, 32'h1234_5678);
    chk("t2_status", wo21, 32'h0002_0000);

    // 3: W accepted 4 cycles before AW; bready waits for both
    ar_dly = 0; r_dly = 0; aw_dly = 4; w_dly = 0;
    start(32'h0000_2007, 32'hA5A5_A5A5, 32'h0000_0031);
    tick();
    chk("t3_awaddr", m_axi_awaddr, 32'h0000_2004);
    chk("t3_wstrb", {28'd0, m_axi_wstrb}, 32'h3);
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk("t3_aw_pending", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'b100);
    end
    tick();
    chk("t3_both_done", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'b001);
    tick();
    chk("t3_done", to60, 32'd1);
    chk("t3_status", wo21, 32'h0003_0000);

    // 4: read answered with SLVERR
    aw_dly = 0; s_rresp = RESP_SLVERR; s_rdata = 32'hCAFE_F00D;
    start(32'h0000_0100, 32'd0, 32'd0);
    wait_done(10, n);
    chk("t4_latency", n, 32'd3);
    chk("t4_trig", to60, 32'd3);
    chk("t4_rdata", wo20, 32'hCAFE_F00D);
    chk("t4_status", wo21, 32'h0004_0004);

    // 5: slave never accepts AR -> abort on the 16th edge after start
    s_rresp = RESP_OKAY; ar_dly = 1000;
    start(32'h0000_3000, 32'd0, 32'd0);
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk("t5_arvalid_held", {31'd0, m_axi_arvalid}, 32'd1);
    end
    tick();
    chk("t5_arvalid_drop", {31'd0, m_axi_arvalid}, 32'd0);
    chk("t5_trig", to60, 32'd2);
    chk("t5_status", wo21, 32'h0004_000C);
    ar_dly = 0;
    pulse_reset();

    // 6: start while busy sets overrun, then reset mid-write
    aw_dly = 20; w_dly = 20;
    start(32'h0000_0040, 32'h0000_0001, 32'h0000_00F1);
    tick();
    ti40 = 32'd1;
    tick();
    ti40 = 32'd0;
    chk("t6_overrun", wo21 & 32'h1F, 32'h11);
    chk("t6_still_writing", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'd3);
    pulse_reset();
    aw_dly = 0; w_dly = 0;

    // 7: start landing on the completion edge is ignored but flags overrun
    s_rdata = 32'h0BAD_F00D;
    start(32'h0000_0050, 32'd0, 32'd0);
    tick(); tick();
    ti40 = 32'd1;
    tick();
    ti40 = 32'd0;
    chk("t7_done", to60, 32'd1);
    chk("t7_status", wo21, 32'h0001_0010);
    tick();
    chk("t7_no_new_txn", wo21, 32'h0001_0010);

    // 8: fresh write clears overrun
    start(32'h0000_0060, 32'h5555_AAAA, 32'h0000_00F1);
    wait_done(10, n);
    chk("t8_latency", n, 32'd3);
    chk("t8_status", wo21, 32'h0002_0000);

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

endmodule

// File: doc/fp_axil_master.md
# fp_axil_master

FrontPanel-driven single-beat AXI4-Lite master. It sits directly downstream of the FrontPanel AXI reset stage and shares its `sync_clk`. It is held in reset by that stage's active-high `peripheral_reset`. The host sets up address, data and direction on wire-ins, fires a trigger, and collects read data, response code and completion or timeout status on wire-outs and a trigger-out.

## Interface
- `TIMEOUT_CYCLES`, default 1024: sync_clk cycles allowed per transaction before abort; legal range 16..65535.
- `sync_clk`  in  1  sole clock; the FrontPanel endpoints and the AXI bus are both in this domain.
- `peripheral_reset`  in  1  asynchronous, active-high reset.
- `wi01_ep_dataout_addr`  in  32  AXI byte address; bits [1:0] are forced to 0 on `awaddr`/`araddr`.
- `wi02_ep_dataout_wdata`  in  32  write data.
- `wi03_ep_dataout_ctrl`  in  32  bit0 = 1 write / 0 read; bits [7:4] = `wstrb`; other bits ignored.
- `ti40_ep_trigger`  in  32  bit0 = start; one-cycle pulse.
- `to60_ep_trigger`  out  32  bit0 = done pulse; bit1 = error pulse; other bits 0.
- `wo20_ep_datain_rdata`  out  32  last captured read data.
- `wo21_ep_datain_status`  out  32  bit0 busy; [2:1] last resp; bit3 timeout; bit4 overrun (sticky); [31:16] completed-transaction count.
- AXI4-Lite master ports: `m_axi_awaddr[31:0]`, `awprot[2:0]` (tied 0), `awvalid`/`awready`, `wdata[31:0]`, `wstrb[3:0]`, `wvalid`/`wready`, `bresp[1:0]`, `bvalid`/`bready`, `araddr[31:0]`, `arprot[2:0]` (tied 0), `arvalid`/`arready`, `rdata[31:0]`, `rresp[1:0]`, `rvalid`/`rready`.

## Operation
- FSM states: IDLE, WRITE (AW/W outstanding), WRESP, READ (AR outstanding), RDATA.
- Start in IDLE:
  - Latch addr, wdata, ctrl and clear timeout.
  - Go to WRITE if ctrl[0] = 1, else READ.
  - Clear overrun.
- WRITE:
  - Assert `awvalid` and `wvalid` together.
  - Drop each valid independently on its own handshake. The AW and W handshakes may occur in either order or in the same cycle.
  - Once both handshakes are done, go to WRESP.
- WRESP:
  - `bready` = 1.
  - On `bvalid`, capture `bresp` into status[2:1], then go to IDLE.
- READ: assert `arvalid` until `arready`, then go to RDATA.
- RDATA:
  - `rready` = 1.
  - On `rvalid`, capture `rdata` and `rresp`, then go to IDLE.
- Completion:
  - Pulse done for one cycle.
  - Increment the count, wrapping 0xFFFF→0.
  - If resp ≠ OKAY, also pulse error in the same cycle.
- Timeout:
  - A 16-bit counter clears on start and increments every non-IDLE cycle.
  - When it reaches `TIMEOUT_CYCLES`: drop all valids/readies, set status bit3, pulse error (no done), go to IDLE.
  - Count is unchanged.
  - The host must then pulse the AXI reset before the next transaction.
- Start while busy: ignored; sets overrun.
- Start in the same cycle as completion: ignored, because busy is still 1 that cycle.
- busy = (state ≠ IDLE).

## Timing
- Reset values: every AXI valid/ready = 0; FSM in IDLE; rdata, status, triggers and counters = 0.
- Start sampled at edge N → valids high after edge N+1.
- Final B/R handshake at edge M:
  - done/error pulse, rdata and status all update after edge M.
  - busy = 0 after edge M.
- Minimum read with zero-wait slave: 3 cycles from start to done; minimum write: 3 cycles.
- All outputs are registered; there is no combinational path from any AXI input to any AXI output.
- Reset asserted mid-transaction clears everything immediately. Reset deassertion is synchronous to `sync_clk` upstream.

## Structure
- Package `fp_axil_pkg`:
  - FSM state enum.
  - Status bit indices.
  - AXI resp constants (OKAY = 2'b00, SLVERR = 2'b10).
  - Ctrl field positions.
- Sub-module `fp_axil_timeout`: loadable 16-bit counter with a `clear` input, an `en` input and an `expired` flag.

## Test plan
- Write 0xDEADBEEF to 0x0000_1004, `wstrb` 0xF, zero-wait slave, bresp OKAY → AW and W handshakes in the same cycle; done pulse 3 cycles after start; status = 0x0001_0000.
- Read 0x0000_1004 with `arready` delayed 5 cycles and `rvalid` delayed 2 more, rdata 0x12345678 → wo20 = 0x12345678; done pulse; status[2:1] = 0.
- Write with `wready` asserted 4 cycles before `awready` → each valid drops on its own handshake; `bready` rises only after both handshakes.
- Read returns rresp SLVERR → done and error pulse in the same cycle; status[2:1] = 2'b10.
- Slave never asserts `arready`, `TIMEOUT_CYCLES` = 16 → `arvalid` drops after 16 cycles; error pulse, no done; status bit3 = 1; count unchanged.
- Start pulse while busy, then reset asserted mid-write → overrun = 1; after reset all outputs = 0 and state is IDLE.
